// File: rtl/lib_cpu.sv
// Shared CPU definitions: opcodes, multicycle controller states and datapath
// select encodings, plus the packed control vector driven by the controller.
package lib_cpu;

    typedef logic [5:0] opecode_t;

    localparam opecode_t OP_RTYPE = 6'h00;
    localparam opecode_t OP_J     = 6'h02;
    localparam opecode_t OP_BEQ   = 6'h04;
    localparam opecode_t OP_ADDI  = 6'h08;
    localparam opecode_t OP_LW    = 6'h23;
    localparam opecode_t OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_MEMADR,
        ST_MEMRD,
        ST_MEMWB,
        ST_MEMWR,
        ST_EXEC,
        ST_ALUWB,
        ST_BRANCH,
        ST_ADDIEX,
        ST_ADDIWB,
        ST_JUMP,
        ST_TRAP
    } mc_state_e;

    typedef enum logic [1:0] {
        SRCB_REG    = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_BRANCH = 2'b11
    } alu_srcb_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_src_e;

    typedef struct packed {
        logic      mem_req;
        logic      iord;
        logic      mem_write;
        logic      ir_write;
        logic      pc_write;
        logic      branch;
        logic      mem_to_reg;
        logic      reg_dst;
        logic      reg_write;
        logic      alu_srca;
        alu_srcb_e alu_srcb;
        alu_op_e   alu_op;
        pc_src_e   pc_src;
        logic      trap;
    } ctrl_t;

    function automatic logic is_mem_op(opecode_t op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory request/acknowledge bus between the multicycle controller and memory.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_ack;
    logic iord;
    logic mem_write;

    modport master (output mem_req, output iord, output mem_write, input mem_ack);
    modport slave  (input mem_req, input iord, input mem_write, output mem_ack);
endinterface

// File: rtl/mc_out_dec.sv
// Combinational decoder from controller state and memory acknowledge to the
// datapath control vector; anything not set for a state stays 0.
module mc_out_dec
    import lib_cpu::*;
(
    input  mc_state_e state,
    input  logic      mem_ack,
    output ctrl_t     ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_req  = 1'b1;
                ctrl.alu_srcb = SRCB_FOUR;
                ctrl.alu_op   = ALUOP_ADD;
                ctrl.pc_src   = PCSRC_ALU;
                // IR and PC load only on the cycle the instruction word arrives
                ctrl.ir_write = mem_ack;
                ctrl.pc_write = mem_ack;
            end
            ST_DECODE: begin
                ctrl.alu_srcb = SRCB_BRANCH;
                ctrl.alu_op   = ALUOP_ADD;
            end
            ST_MEMADR: begin
                ctrl.alu_srca = 1'b1;
                ctrl.alu_srcb = SRCB_IMM;
                ctrl.alu_op   = ALUOP_ADD;
            end
            ST_MEMRD: begin
                ctrl.iord    = 1'b1;
                ctrl.mem_req = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            ST_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_req   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            ST_EXEC: begin
                ctrl.alu_srca = 1'b1;
                ctrl.alu_srcb = SRCB_REG;
                ctrl.alu_op   = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_srca = 1'b1;
                ctrl.alu_srcb = SRCB_REG;
                ctrl.alu_op   = ALUOP_SUB;
                ctrl.branch   = 1'b1;
                ctrl.pc_src   = PCSRC_ALUOUT;
            end
            ST_ADDIEX: begin
                ctrl.alu_srca = 1'b1;
                ctrl.alu_srcb = SRCB_IMM;
                ctrl.alu_op   = ALUOP_ADD;
            end
            ST_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_JUMP;
            end
            ST_TRAP: begin
                ctrl.trap = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU controller: state register, next-state logic and retire pulse.
// Optional retired-instruction counter is built when MC_PERF_EN is defined.
module multicycle_ctrl
    import lib_cpu::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  opecode_t                  op,
    multicycle_ctrl_if.master         mem,
    output logic                      ir_write,
    output logic                      pc_write,
    output logic                      branch,
    output logic                      mem_to_reg,
    output logic                      reg_dst,
    output logic                      reg_write,
    output logic                      alu_srcA,
    output logic [1:0]                alu_srcB,
    output logic [1:0]                alu_op,
    output logic [1:0]                pc_src,
    output logic                      retired,
    output logic                      trap
`ifdef MC_PERF_EN
    ,
    output logic [CNT_W-1:0]          instr_cnt
`endif
);

    if (CNT_W < 1) begin : g_cnt_w_chk
        $error("CNT_W must be at least 1");
    end

    mc_state_e state;
    ctrl_t     ctrl;
    logic      ack;

    // Reset masks the acknowledge so no FETCH-cycle load leaks out while held.
    assign ack = mem.mem_ack & rst_n;

    mc_out_dec u_dec (
        .state   (state),
        .mem_ack (ack),
        .ctrl    (ctrl)
    );

    assign mem.mem_req   = ctrl.mem_req & rst_n;
    assign mem.iord      = ctrl.iord;
    assign mem.mem_write = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign pc_write      = ctrl.pc_write;
    assign branch        = ctrl.branch;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_srcA      = ctrl.alu_srca;
    assign alu_srcB      = ctrl.alu_srcb;
    assign alu_op        = ctrl.alu_op;
    assign pc_src        = ctrl.pc_src;
    assign trap          = ctrl.trap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_FETCH;
            retired <= 1'b0;
        end else begin
            retired <= 1'b0;
            case (state)
                ST_FETCH:  if (ack) state <= ST_DECODE;
                ST_DECODE: begin
                    if (is_mem_op(op))       state <= ST_MEMADR;
                    else if (op == OP_RTYPE) state <= ST_EXEC;
                    else if (op == OP_BEQ)   state <= ST_BRANCH;
                    else if (op == OP_ADDI)  state <= ST_ADDIEX;
                    else if (op == OP_J)     state <= ST_JUMP;
                    else                     state <= ST_TRAP;
                end
                ST_MEMADR: state <= (op == OP_SW) ? ST_MEMWR : ST_MEMRD;
                ST_MEMRD:  if (ack) state <= ST_MEMWB;
                ST_MEMWR: begin
                    if (ack) begin
                        state   <= ST_FETCH;
                        retired <= 1'b1;
                    end
                end
                ST_EXEC:   state <= ST_ALUWB;
                ST_ADDIEX: state <= ST_ADDIWB;
                ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_ADDIWB, ST_JUMP: begin
                    state   <= ST_FETCH;
                    retired <= 1'b1;
                end
                // TRAP only leaves through reset
                ST_TRAP:   state <= ST_TRAP;
                default:   state <= ST_TRAP;
            endcase
        end
    end

`ifdef MC_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt <= '0;
        end else if (retired) begin
            instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl; instr_cnt is checked
// only when MC_PERF_EN is defined.
module tb_multicycle_ctrl;
    import lib_cpu::*;

    logic       clk = 1'b0;
    logic       rst_n;
    opecode_t   op;
    logic       ir_write, pc_write, branch, mem_to_reg, reg_dst, reg_write;
    logic       alu_srcA, retired, trap;
    logic [1:0] alu_srcB, alu_op, pc_src;
`ifdef MC_PERF_EN
    logic [3:0] instr_cnt;
`endif

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .mem        (bus),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .branch     (branch),
        .mem_to_reg (mem_to_reg),
        .reg_dst    (reg_dst),
        .reg_write  (reg_write),
        .alu_srcA   (alu_srcA),
        .alu_srcB   (alu_srcB),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .retired    (retired),
        .trap       (trap)
`ifdef MC_PERF_EN
        ,
        .instr_cnt  (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit pend_ret = 1'b0;
    int model_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int base_lat(opecode_t o);
        case (o)
            OP_LW:                     return 5;
            OP_SW, OP_RTYPE, OP_ADDI:  return 4;
            default:                   return 3;
        endcase
    endfunction

    function automatic bit legal(opecode_t o);
        return o == OP_LW || o == OP_SW || o == OP_RTYPE ||
               o == OP_ADDI || o == OP_BEQ || o == OP_J;
    endfunction

    function automatic int b2i(bit b);
        return b ? 1 : 0;
    endfunction

    // First cycle of an instruction must be FETCH carrying the previous retire.
    task automatic cycle_start(input int c);
        @(negedge clk);
        if (c == 1) begin
            check("retired_on_fetch", retired, pend_ret);
            check("fetch_state", {bus.mem_req, bus.iord}, 2'b10);
            if (pend_ret) model_cnt = (model_cnt + 1) % 16;
            pend_ret = 1'b0;
        end
`ifdef MC_PERF_EN
        if (c == 2) check("instr_cnt", instr_cnt, model_cnt);
`endif
    endtask

    // Memory responder: fetches wait fw cycles, data accesses mw cycles.
    task automatic drive_mem(input opecode_t o, input int fw, input int mw,
                             inout int fcnt, inout int dcnt);
        if (bus.mem_req && !bus.iord) begin
            op = 6'($urandom);
            bus.mem_ack = (fcnt >= fw);
            fcnt++;
        end else if (bus.mem_req) begin
            op = o;
            bus.mem_ack = (dcnt >= mw);
            dcnt++;
        end else begin
            op = o;
            bus.mem_ack = 1'($urandom_range(0, 1));
        end
        #1;
    endtask

    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        bus.mem_ack = 1'b1;
        #1;
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_ir_write", ir_write, 0);
        check("rst_pc_write", pc_write, 0);
        check("rst_iord", bus.iord, 0);
        check("rst_reg_write", reg_write, 0);
        check("rst_trap", trap, 0);
        check("rst_retired", retired, 0);
        check("rst_alu_srcB", alu_srcB, 2'b01);
`ifdef MC_PERF_EN
        check("rst_instr_cnt", instr_cnt, 0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.mem_ack = 1'b0;
        pend_ret = 1'b0;
        model_cnt = 0;
    endtask

    task automatic run_instr(input opecode_t o, input int fw, input int mw);
        int lat, fcnt, dcnt;
        int n_ir, n_pc, n_mw, n_rw, n_br, n_req, n_iord, n_m2r, n_rd, n_tr, n_sb3, n_fn, n_sel;
        bit early, stab, mop;
        logic p_req, p_ack, p_iord, p_mwr;
        mop = (o == OP_LW) || (o == OP_SW);
        lat = base_lat(o) + fw + (mop ? mw : 0);
        {fcnt, dcnt, n_ir, n_pc, n_mw, n_rw, n_br} = '0;
        {n_req, n_iord, n_m2r, n_rd, n_tr, n_sb3, n_fn, n_sel} = '0;
        early = 1'b0; stab = 1'b1;
        {p_req, p_ack, p_iord, p_mwr} = '0;
        for (int c = 1; c <= lat; c++) begin
            cycle_start(c);
            if (c > 1 && retired) early = 1'b1;
            drive_mem(o, fw, mw, fcnt, dcnt);
            n_ir += b2i(ir_write);   n_pc += b2i(pc_write);  n_mw += b2i(bus.mem_write);
            n_rw += b2i(reg_write);  n_br += b2i(branch);    n_req += b2i(bus.mem_req);
            n_iord += b2i(bus.iord); n_m2r += b2i(mem_to_reg); n_rd += b2i(reg_dst);
            n_tr += b2i(trap);       n_sb3 += b2i(alu_srcB == 2'b11);
            n_fn += b2i(alu_op == 2'b10);
            if (ir_write && (pc_src != 2'b00 || alu_srcB != 2'b01 || alu_op != 2'b00)) n_sel++;
            if (branch && (pc_src != 2'b01 || alu_op != 2'b01 || !alu_srcA)) n_sel++;
            if (pc_write && !ir_write && pc_src != 2'b10) n_sel++;
            if (reg_write && reg_dst != (o == OP_RTYPE)) n_sel++;
            if (p_req && !p_ack && (!bus.mem_req || bus.iord != p_iord || bus.mem_write != p_mwr))
                stab = 1'b0;
            p_req = bus.mem_req; p_ack = bus.mem_ack; p_iord = bus.iord; p_mwr = bus.mem_write;
        end
        check($sformatf("ir_write_n op=%0h", o), n_ir, 1);
        check($sformatf("pc_write_n op=%0h", o), n_pc, 1 + b2i(o == OP_J));
        check($sformatf("mem_write_n op=%0h", o), n_mw, (o == OP_SW) ? 1 + mw : 0);
        check($sformatf("reg_write_n op=%0h", o), n_rw,
              b2i(o == OP_LW || o == OP_RTYPE || o == OP_ADDI));
        check($sformatf("branch_n op=%0h", o), n_br, b2i(o == OP_BEQ));
        check($sformatf("mem_req_n op=%0h", o), n_req, 1 + fw + (mop ? 1 + mw : 0));
        check($sformatf("iord_n op=%0h", o), n_iord, mop ? 1 + mw : 0);
        check($sformatf("mem_to_reg_n op=%0h", o), n_m2r, b2i(o == OP_LW));
        check($sformatf("reg_dst_n op=%0h", o), n_rd, b2i(o == OP_RTYPE));
        check($sformatf("decode_srcB_n op=%0h", o), n_sb3, 1);
        check($sformatf("funct_op_n op=%0h", o), n_fn, b2i(o == OP_RTYPE));
        check($sformatf("trap_n op=%0h", o), n_tr, 0);
        check($sformatf("select_err op=%0h", o), n_sel, 0);
        check($sformatf("retired_early op=%0h", o), early, 0);
        check($sformatf("req_stable op=%0h", o), stab, 1);
        pend_ret = 1'b1;
    endtask

    task automatic run_trap(input int fw);
        int fcnt, dcnt, n_ir, n_tr, n_req, n_en, n_ret;
        opecode_t bad_op;
        {fcnt, dcnt, n_ir, n_tr, n_req, n_en, n_ret} = '0;
        bad_op = 6'h3F;
        for (int c = 1; c <= fw + 2; c++) begin
            cycle_start(c);
            drive_mem(bad_op, fw, 0, fcnt, dcnt);
            n_ir += b2i(ir_write);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.mem_ack = 1'($urandom_range(0, 1));
            op = 6'($urandom);
            #1;
            n_tr += b2i(trap);
            n_req += b2i(bus.mem_req);
            n_en += b2i(ir_write | pc_write | bus.mem_write | reg_write | branch | bus.iord);
            n_ret += b2i(retired);
        end
        check("trap_ir_write_n", n_ir, 1);
        check("trap_held_n", n_tr, 10);
        check("trap_mem_req_n", n_req, 0);
        check("trap_enables_n", n_en, 0);
        check("trap_retired_n", n_ret, 0);
        apply_reset();
    endtask

    task automatic run_lw_abort(input int fw);
        int fcnt, dcnt, n_rw, n_iord;
        {fcnt, dcnt, n_rw, n_iord} = '0;
        for (int c = 1; c <= fw + 5; c++) begin
            cycle_start(c);
            drive_mem(OP_LW, fw, 8, fcnt, dcnt);
            n_rw += b2i(reg_write);
            n_iord += b2i(bus.iord);
        end
        check("abort_in_memrd", {bus.mem_req, bus.iord}, 2'b11);
        check("abort_iord_n", n_iord, 2);
        apply_reset();
        check("abort_reg_write_n", n_rw, 0);
    endtask

    task automatic flush();
        bus.mem_ack = 1'b0;
        cycle_start(1);
        cycle_start(2);
    endtask

    initial begin
        opecode_t ops [6];
        opecode_t o;
        ops = '{OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_BEQ, OP_J};
        rst_n = 1'b1;
        op = '0;
        bus.mem_ack = 1'b0;
        #12;
        apply_reset();
        run_instr(OP_RTYPE, 0, 0);
        run_instr(OP_LW, 2, 1);
        flush();
        apply_reset();
        run_instr(OP_SW, 0, 0);
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_J, 0, 0);
        flush();
        run_trap(1);
        run_instr(OP_ADDI, 0, 0);
        run_lw_abort(1);
        for (int i = 0; i < 16; i++) run_instr(OP_ADDI, 0, 0);
        flush();
        for (int i = 0; i < 40; i++) begin
            o = ops[$urandom_range(0, 5)];
            run_instr(o, $urandom_range(0, 2), $urandom_range(0, 2));
        end
        flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
